// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: reorders bit-reversed FFT output frames into natural order.
// Two-bank ping-pong store; one frame is written while the other drains.
// Optional sticky overflow flag on port ovf, enabled by defining FFT_REORDER_OVF_EN.
// Sample width comes from the global `W macro (defaults to 16 if not set).
`ifndef W
`define W 16
`endif

module fft_reorder_buf #(
    parameter int unsigned LOG2N = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [`W-1:0] i_re,
    input  logic [`W-1:0] i_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [`W-1:0] o_re,
    output logic [`W-1:0] o_im,
    output logic          o_last
`ifdef FFT_REORDER_OVF_EN
    ,
    output logic          ovf
`endif
);

    localparam int unsigned DW = `W;
    localparam int unsigned N  = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    // Reverse the bit order of a LOG2N-bit index.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

    // Two banks of N complex words, {re, im}.
    logic [2*DW-1:0] mem_q [2][N];

    logic [LOG2N-1:0] wcnt_q,  wcnt_d;
    logic             wsel_q,  wsel_d;
    logic [LOG2N-1:0] rcnt_q,  rcnt_d;
    logic             rsel_q,  rsel_d;
    logic [1:0]       full_q,  full_d;
    logic             ovld_q,  ovld_d;
    logic [DW-1:0]    ore_q,   ore_d;
    logic [DW-1:0]    oim_q,   oim_d;
    logic             olast_q, olast_d;

    logic             wr_fire;
    logic             ld_fire;
    logic [2*DW-1:0]  rd_word;

    // Handshake decode and bank read port.
    assign in_ready = ~full_q[wsel_q];
    assign wr_fire  = in_valid & in_ready;
    assign ld_fire  = full_q[rsel_q] & (~ovld_q | out_ready);
    assign rd_word  = mem_q[rsel_q][rcnt_q];

    // Write side next state: bit-reversed address counter and bank hand-off.
    always_comb begin
        wcnt_d = wcnt_q;
        wsel_d = wsel_q;
        if (wr_fire) begin
            wcnt_d = wcnt_q + LOG2N'(1);
            if (wcnt_q == LAST_IDX) begin
                wsel_d = ~wsel_q;
            end
        end
    end

    // Read side next state: natural-order counter and output register load.
    always_comb begin
        rcnt_d  = rcnt_q;
        rsel_d  = rsel_q;
        ovld_d  = ovld_q;
        ore_d   = ore_q;
        oim_d   = oim_q;
        olast_d = olast_q;
        if (ld_fire) begin
            ore_d   = rd_word[2*DW-1:DW];
            oim_d   = rd_word[DW-1:0];
            olast_d = (rcnt_q == LAST_IDX);
            ovld_d  = 1'b1;
            rcnt_d  = rcnt_q + LOG2N'(1);
            if (rcnt_q == LAST_IDX) begin
                rsel_d = ~rsel_q;
            end
        end else if (out_ready) begin
            ovld_d = 1'b0;
        end
    end

    // Full flags: read clears its bank, write sets the other; never the same bank.
    always_comb begin
        full_d = full_q;
        if (ld_fire && (rcnt_q == LAST_IDX)) begin
            full_d[rsel_q] = 1'b0;
        end
        if (wr_fire && (wcnt_q == LAST_IDX)) begin
            full_d[wsel_q] = 1'b1;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q  <= '0;
            wsel_q  <= 1'b0;
            rcnt_q  <= '0;
            rsel_q  <= 1'b0;
            full_q  <= 2'b00;
            ovld_q  <= 1'b0;
            ore_q   <= '0;
            oim_q   <= '0;
            olast_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            wsel_q  <= wsel_d;
            rcnt_q  <= rcnt_d;
            rsel_q  <= rsel_d;
            full_q  <= full_d;
            ovld_q  <= ovld_d;
            ore_q   <= ore_d;
            oim_q   <= oim_d;
            olast_q <= olast_d;
        end
    end

    // Sample storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wsel_q][bitrev(wcnt_q)] <= {i_re, i_im};
        end
    end

    assign out_valid = ovld_q;
    assign o_re      = ore_q;
    assign o_im      = oim_q;
    assign o_last    = olast_q;

`ifdef FFT_REORDER_OVF_EN
    logic ovf_q;

    // Sticky flag for any sample offered while the write bank is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid && !in_ready) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Testbench for fft_reorder_buf: random frames checked against a natural-order scoreboard.
// Optional overflow checks are compiled when FFT_REORDER_OVF_EN is defined.
`ifndef W
`define W 16
`endif

module tb_fft_reorder_buf;

    localparam int W     = `W;
    localparam int LOG2N = 4;
    localparam int N     = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  i_re;
    logic [W-1:0]  i_im;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  o_re;
    logic [W-1:0]  o_im;
    logic          o_last;
`ifdef FFT_REORDER_OVF_EN
    logic          ovf;
`endif

    fft_reorder_buf #(.LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_re      (i_re),
        .i_im      (i_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o_re      (o_re),
        .o_im      (o_im),
        .o_last    (o_last)
`ifdef FFT_REORDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the frame being sent, held in natural order.
    logic [W-1:0]   nat_re [N];
    logic [W-1:0]   nat_im [N];
    int             in_pos;
    int             out_idx;
    logic [2*W-1:0] exp_q [$];
    logic           hold_v;
    logic [2*W-1:0] hold_val;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt, drop_cnt, nrdy_cnt, out_cnt;
    logic s_out_fire, s_last, s_in_ready, s_prev_in_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Index reversal computed arithmetically.
    function automatic int br(input int a);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r = r * 2 + ((a >> i) & 1);
        return r;
    endfunction

    task automatic new_frame(input bit identity);
        for (int k = 0; k < N; k++) begin
            nat_re[k] = identity ? W'(k) : W'($urandom);
            nat_im[k] = W'($urandom);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        in_pos  = 0;
        out_idx = 0;
        hold_v  = 1'b0;
        new_frame(1'b0);
    endtask

    // Present the sample for the next bit-reversed slot.
    task automatic drive();
        i_re = nat_re[br(in_pos)];
        i_im = nat_im[br(in_pos)];
    endtask

    // Sample at the falling edge, update the model, then advance to just after the next rising edge.
    task automatic step();
        logic [2*W-1:0] e;
        @(negedge clk);
        s_out_fire      = 1'b0;
        s_last          = o_last;
        s_prev_in_ready = s_in_ready;
        s_in_ready      = in_ready;
        if (!rst) begin
            if (hold_v)
                check("hold_stable", 64'({out_valid, o_re, o_im}), 64'({1'b1, hold_val}));
            if (out_valid && out_ready) begin
                s_out_fire = 1'b1;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("o_re", 64'(o_re), 64'(e[2*W-1:W]));
                    check("o_im", 64'(o_im), 64'(e[W-1:0]));
                    check("o_last", 64'(o_last), 64'(out_idx == N - 1));
                    out_idx = (out_idx + 1) % N;
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_val = {o_re, o_im};
            if (!in_ready) nrdy_cnt++;
            if (in_valid && !in_ready) drop_cnt++;
            if (in_valid && in_ready) begin
                acc_cnt++;
                in_pos++;
                if (in_pos == N) begin
                    for (int k = 0; k < N; k++) exp_q.push_back({nat_re[k], nat_im[k]});
                    in_pos = 0;
                    new_frame(1'b0);
                end
            end
        end else begin
            hold_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int c = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && c < 300) begin
            step();
            c++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_idle"}, 64'(out_valid), 64'(0));
    endtask

    task automatic async_reset_check(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_ovalid"}, 64'(out_valid), 64'(0));
        check({tag, "_ore_oim"}, 64'({o_re, o_im}), 64'(0));
        check({tag, "_olast"}, 64'(o_last), 64'(0));
        check({tag, "_inrdy"}, 64'(in_ready), 64'(1));
        model_reset();
        step();
        rst = 1'b0;
    endtask

    task automatic single_frame(input string tag);
        new_frame(1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            drive();
            step();
        end
        in_valid = 1'b0;
        check({tag, "_lat_pre"}, 64'(out_valid), 64'(0));
        step();
        check({tag, "_lat_first"}, 64'({out_valid, o_re}), 64'({1'b1, W'(0)}));
        drain(tag);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        i_re      = '0;
        i_im      = '0;
        s_in_ready = 1'b0;
        acc_cnt = 0; drop_cnt = 0; nrdy_cnt = 0; out_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovalid", 64'(out_valid), 64'(0));
        check("rst_out", 64'({o_re, o_im, o_last}), 64'(0));
        check("rst_inrdy", 64'(in_ready), 64'(1));
`ifdef FFT_REORDER_OVF_EN
        check("rst_ovf", 64'(ovf), 64'(0));
`endif
        rst = 1'b0;

        // Identity frame: output must be re = 0..15.
        single_frame("single");

        // Four back-to-back frames at full rate.
        nrdy_cnt = 0; out_cnt = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4 * N; c++) begin
            drive();
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < N + 1; c++) step();
        check("stream_inrdy_drops", 64'(nrdy_cnt), 64'(0));
        check("stream_outputs", 64'(out_cnt), 64'(4 * N));
        drain("stream");

        // Backpressure: 40 offers with the output stalled.
        acc_cnt = 0; drop_cnt = 0;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            drive();
            step();
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc_cnt), 64'(2 * N));
        check("bp_dropped", 64'(drop_cnt), 64'(40 - 2 * N));
        check("bp_inrdy", 64'(in_ready), 64'(0));
        check("bp_frozen", 64'({out_valid, o_re}), 64'({1'b1, exp_q[0][2*W-1:W]}));
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (s_out_fire && s_last) begin
                check("bp_rdy_after_final_load", 64'(s_in_ready), 64'(1));
                check("bp_rdy_before_final_load", 64'(s_prev_in_ready), 64'(0));
                seen = 1'b1;
            end
        end
        if (!seen) check("bp_release_timeout", 64'(0), 64'(1));
        drain("bp");

        // Random downstream readiness with mostly continuous input.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            drive();
            step();
        end
        drain("rand");

        // Reset in the middle of streaming, then a fresh frame.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < N + 5; c++) begin
            drive();
            step();
        end
        async_reset_check("midrst");
        single_frame("after_rst");

`ifdef FFT_REORDER_OVF_EN
        async_reset_check("ovf_pre");
        check("ovf_clear", 64'(ovf), 64'(0));
        acc_cnt = 0;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 2 * N; c++) begin
            drive();
            step();
        end
        check("ovf_fill_acc", 64'(acc_cnt), 64'(2 * N));
        check("ovf_none_yet", 64'({ovf, in_ready}), 64'(0));
        i_re = W'(16'hDEAD);
        i_im = W'(16'hBEEF);
        step();
        in_valid = 1'b0;
        step();
        check("ovf_set", 64'(ovf), 64'(1));
        drain("ovf");
        check("ovf_sticky", 64'(ovf), 64'(1));
        rst = 1'b1;
        #1;
        check("ovf_rst", 64'(ovf), 64'(0));
        model_reset();
        step();
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fft_reorder_buf.md
Name: fft_reorder_buf

Overview:
- Output reorder buffer for the streaming FFT datapath.
- Accepts complex samples in bit-reversed index order, one frame of N points at a time, as the pipelined FFT stages produce them.
- Emits each frame in natural order over a valid/ready stream.
- Ping-pong (two-bank) storage: the next frame is written while the previous one drains.

Parameters:
- LOG2N, 4, log2 of frame length; N = 2**LOG2N points per frame.
- Sample width is the global `W (width.vh) for each of re/im; not a module parameter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample present on i_re/i_im
- in_ready  out  1  buffer can accept a sample this cycle
- i_re  in  `W  input sample, real part (bit-reversed order)
- i_im  in  `W  input sample, imaginary part
- out_valid  out  1  o_re/o_im hold a valid sample
- out_ready  in  1  downstream accepts sample this cycle
- o_re  out  `W  output sample, real part (natural order)
- o_im  out  `W  output sample, imaginary part
- o_last  out  1  marks natural index N-1 of a frame
- ovf  out  1  sticky overflow flag (only with FFT_REORDER_OVF_EN)

Behaviour:
- Storage: two banks of N complex words. Each bank has a full flag. Write select wsel and read select rsel are 1 bit each.
- Reset (async, rst=1): wcnt=0, rcnt=0, wsel=0, rsel=0, both full flags=0, out_valid=0, o_re=0, o_im=0, o_last=0, ovf=0. Memory contents are don't-care.
- Write side:
  - in_ready = !full[wsel].
  - Write fires when in_valid && in_ready. Sample goes to bank[wsel] at address bitrev(wcnt) (LOG2N-bit reversal); wcnt increments.
  - When a write fires with wcnt==N-1: wcnt wraps to 0, full[wsel] sets, wsel toggles.
  - in_valid while !in_ready: no write, no counter change.
- Read side:
  - Load condition: full[rsel] && (!out_valid || out_ready).
  - On load: o_re/o_im <= bank[rsel][rcnt], o_last <= (rcnt==N-1), out_valid <= 1, rcnt increments.
  - On load with rcnt==N-1: rcnt wraps to 0, full[rsel] clears, rsel toggles.
  - No load && out_ready: out_valid <= 0.
  - Output holds stable while out_valid && !out_ready.
- Latency:
  - The last write of a frame occurs at edge t; out_valid rises at edge t+1 if the output register is free. The first output is natural index 0.
  - With out_ready held at 1, a frame drains in N consecutive cycles with no bubbles.
- Throughput: with out_ready=1, input may run at 1 sample/cycle indefinitely; in_ready never drops.
- Simultaneous events:
  - The same-cycle clear of full[rsel] by the read side and set of full[wsel] by the write side on different banks are independent and both take effect.
  - A bank freed by its final load is writable from the next cycle: in_ready rises one cycle after that load.
- Backpressure: with out_ready=0, at most two frames are buffered plus one sample in the output register. in_ready then stays 0 until the drain resumes.
- Reset mid-frame discards partial and buffered frames. After release, the next accepted sample is treated as bit-reversed index 0.

Optional Feature:
- Macro: FFT_REORDER_OVF_EN.
- Defined:
  - Port ovf exists.
  - ovf sets (sticky) on any cycle with in_valid && !in_ready; cleared only by rst.
  - The offending sample is still dropped.
- Undefined:
  - Port ovf and its logic are absent.
  - in_valid && !in_ready silently drops the sample, with identical datapath behaviour.

Test Plan:
- Reset: assert rst mid-stream -> out_valid=0, o_re=o_im=0, in_ready=1 immediately (async). After release, the first 16 inputs form a new frame.
- Single frame, LOG2N=4, W=16, out_ready=1, input re=k for k=0..15 presented in bit-reversed order:
  - Input sequence is re=0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - Output is re=0..15 in order, starting one cycle after the 16th write.
  - o_last=1 only with re=15.
- Streaming: 4 back-to-back frames at 1 sample/cycle with out_ready=1 -> in_ready constantly 1. Outputs appear as 64 contiguous natural-order samples with o_last every 16th.
- Backpressure:
  - out_ready=0 while driving 40 samples -> in_ready drops after 32 accepted; outputs frozen at re=0 of frame 0.
  - Release out_ready -> in_ready returns 1 one cycle after frame 0's final load; no data lost or reordered.
- Random out_ready (50%) with continuous input -> output sequence matches a natural-order scoreboard, and o_re/o_im are stable whenever out_valid && !out_ready.
- With FFT_REORDER_OVF_EN: force a stall until in_ready=0, then pulse in_valid once -> ovf=1 and stays 1 after the drain; the dropped sample never appears at the output. rst clears ovf.
